// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
//
// Shared definitions for the run-time divide-by-N controller:
//   - state_e     : controller state (IDLE / RUN / DRAIN), 2-bit encoding
//   - DIV_MIN     : smallest legal divide ratio
//   - half_period : threshold below which the divided waveform is high
//
// No ports (package).
// ---------------------------------------------------------------------------
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Ratios below this are rejected; a ratio of 0 or 1 has no usable period.
    localparam int DIV_MIN = 2;

    // The helper is written at a fixed 32-bit width so that it can serve any
    // counter width up to 32 bits; callers cast to and from their own width.
    function automatic logic [31:0] half_period(input logic [31:0] div);
        return div >> 1;
    endfunction

endpackage

// File: rtl/clk_div_counter.sv
// ---------------------------------------------------------------------------
// clk_div_counter
//
// Wrapping counter for the divide-by-N datapath. While enabled it counts
// 0 .. load_div-1 and then returns to 0. While disabled it holds its value.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset (count -> 0)
//   en       in   advance the counter this cycle
//   load_div in   current divide ratio D (>= 2)
//   count    out  registered count value, 0 .. D-1
//   wrap     out  count is at D-1 (last cycle of the period)
// ---------------------------------------------------------------------------
module clk_div_counter
    import clk_div_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] load_div,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // D is at least 2, so D-1 cannot underflow at CNT_W width.
    assign wrap  = (count_q == (load_div - CNT_W'(1)));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (en) begin
            if (wrap) begin
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
//
// Run-time controller for a free-running divide-by-N counter. Start/stop are
// sequenced so that a period is never cut short, and new divide ratios are
// accepted over a valid/ready handshake but only take effect at a period
// boundary.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   level; leave IDLE and begin counting
//   stop       in   level; finish the current period(s) and return to IDLE
//   cfg_valid  in   a new divide ratio is offered
//   cfg_div    in   offered divide ratio D
//   cfg_ready  out  a ratio can be accepted (no ratio is waiting)
//   cfg_err    out  one-cycle pulse: an accepted ratio was < 2 and dropped
//   count      out  live counter value, 0 .. D-1
//   div_out    out  divided waveform, high for the first D>>1 counts
//   tick       out  high during the last cycle of each period
//   busy       out  controller is not IDLE
// ---------------------------------------------------------------------------
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DIV_RST = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [CNT_W-1:0] count,
    output logic             div_out,
    output logic             tick,
    output logic             busy
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] active_div_q;
    logic [CNT_W-1:0] active_div_d;
    logic [CNT_W-1:0] pending_div_q;
    logic [CNT_W-1:0] pending_div_d;
    logic             pending_vld_q;
    logic             pending_vld_d;
    logic             cfg_err_q;
    logic             cfg_err_d;

    logic             running;
    logic             wrap;
    logic             period_end;
    logic             cfg_accept;
    logic             cfg_legal;
    logic [CNT_W-1:0] high_thresh;

    assign running    = (state_q != IDLE);
    assign period_end = running && wrap;
    assign cfg_ready  = !pending_vld_q;
    assign cfg_accept = cfg_valid && cfg_ready;
    assign cfg_legal  = (cfg_div >= CNT_W'(DIV_MIN));

    clk_div_counter #(
        .CNT_W    (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (running),
        .load_div (active_div_q),
        .count    (count),
        .wrap     (wrap)
    );

    // Next-state logic. The counter is cleared by wrapping, so leaving DRAIN
    // only on period_end is what guarantees IDLE always starts from count 0.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (period_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ratio holding. A ratio that arrives while idle can be used at once
    // since no period is in flight; otherwise it waits for the wrap edge.
    // Because acceptance requires an empty holding register, a swap at the
    // wrap and a new acceptance can never collide on the same register
    // value: a ratio accepted on a wrap cycle simply waits for the next wrap.
    always_comb begin
        active_div_d  = active_div_q;
        pending_div_d = pending_div_q;
        pending_vld_d = pending_vld_q;
        cfg_err_d     = cfg_accept && !cfg_legal;

        if (period_end && pending_vld_q) begin
            active_div_d  = pending_div_q;
            pending_vld_d = 1'b0;
        end

        if (cfg_accept && cfg_legal) begin
            if (state_q == IDLE) begin
                active_div_d = cfg_div;
            end else begin
                pending_div_d = cfg_div;
                pending_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            active_div_q  <= CNT_W'(DIV_RST);
            pending_div_q <= '0;
            pending_vld_q <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_div_q  <= active_div_d;
            pending_div_q <= pending_div_d;
            pending_vld_q <= pending_vld_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    // Outputs depend on registered state only.
    assign high_thresh = CNT_W'(half_period(32'(active_div_q)));
    assign busy        = running;
    assign tick        = period_end;
    assign div_out     = running && (count < high_thresh);
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_ctrl
//
// Directed and randomized stimulus for clk_div_ctrl, compared each cycle
// against a behavioural model of the controller kept in this file.
// ---------------------------------------------------------------------------
module tb_clk_div_ctrl;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic [CNT_W-1:0] count;
    logic             div_out;
    logic             tick;
    logic             busy;

    int tests_run = 0;
    int failed    = 0;

    // Behavioural model: mode 0 = idle, 1 = running, 2 = draining.
    int m_mode;
    int m_cnt;
    int m_div;
    int m_pend;
    bit m_pend_vld;
    bit m_err;

    clk_div_ctrl #(
        .CNT_W     (CNT_W),
        .DIV_RST   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .count     (count),
        .div_out   (div_out),
        .tick      (tick),
        .busy      (busy)
    );

    // Free-running 100 MHz-style clock; inputs change and outputs are sampled
    // around the falling edge, well away from the active rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        m_mode     = 0;
        m_cnt      = 0;
        m_div      = 3;
        m_pend     = 0;
        m_pend_vld = 0;
        m_err      = 0;
    endtask

    // One clock of the controller's rules, written in terms of periods:
    // a period runs 0..D-1, a waiting ratio takes over at its end, and
    // draining ends at the first period end.
    task automatic modelStep(bit s, bit p, bit v, int d);
        bit accept;
        bit legal;
        bit period_end;
        accept     = v && !m_pend_vld;
        legal      = (d >= 2);
        period_end = (m_mode != 0) && (m_cnt == m_div - 1);
        m_err      = accept && !legal;

        if (m_mode != 0) m_cnt = period_end ? 0 : m_cnt + 1;
        else             m_cnt = 0;

        if (period_end && m_pend_vld) begin
            m_div      = m_pend;
            m_pend_vld = 0;
        end

        if (accept && legal) begin
            if (m_mode == 0) m_div = d;
            else begin
                m_pend     = d;
                m_pend_vld = 1;
            end
        end

        case (m_mode)
            0: if (s) m_mode = 1;
            1: if (p) m_mode = 2;
            default: if (period_end) m_mode = 0;
        endcase
    endtask

    // Compare every output against what the model says for this cycle.
    task automatic checkOutput(string tag);
        logic             exp_busy;
        logic [CNT_W-1:0] exp_count;
        logic             exp_div;
        logic             exp_tick;
        logic             exp_ready;
        logic             exp_err;
        exp_busy  = (m_mode != 0);
        exp_count = CNT_W'(m_cnt);
        exp_div   = exp_busy && (m_cnt < m_div / 2);
        exp_tick  = exp_busy && (m_cnt == m_div - 1);
        exp_ready = !m_pend_vld;
        exp_err   = m_err;

        tests_run++;
        assert (busy === exp_busy) else begin
            failed++;
            $error("[TB] FAIL %s busy: got %b expected %b", tag, busy, exp_busy);
        end
        tests_run++;
        assert (count === exp_count) else begin
            failed++;
            $error("[TB] FAIL %s count: got %0d expected %0d", tag, count, exp_count);
        end
        tests_run++;
        assert (div_out === exp_div) else begin
            failed++;
            $error("[TB] FAIL %s div_out: got %b expected %b", tag, div_out, exp_div);
        end
        tests_run++;
        assert (tick === exp_tick) else begin
            failed++;
            $error("[TB] FAIL %s tick: got %b expected %b", tag, tick, exp_tick);
        end
        tests_run++;
        assert (cfg_ready === exp_ready) else begin
            failed++;
            $error("[TB] FAIL %s cfg_ready: got %b expected %b", tag, cfg_ready, exp_ready);
        end
        tests_run++;
        assert (cfg_err === exp_err) else begin
            failed++;
            $error("[TB] FAIL %s cfg_err: got %b expected %b", tag, cfg_err, exp_err);
        end
    endtask

    // Drive one cycle of inputs, check the current outputs, then advance
    // both the DUT and the model by one rising edge.
    task automatic applyStimulus(bit s, bit p, bit v, int d, string tag);
        start     = s;
        stop      = p;
        cfg_valid = v;
        cfg_div   = CNT_W'(d);
        checkOutput(tag);
        modelStep(s, p, v, d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic runUntilCount(int target, int limit, string tag);
        int n = 0;
        while ((m_cnt != target || m_mode == 0) && n < limit) begin
            applyStimulus(0, 0, 0, 0, tag);
            n++;
        end
        tests_run++;
        assert (count === CNT_W'(target) && n < limit) else begin
            failed++;
            $error("[TB] FAIL %s reach count: got %0d expected %0d", tag, count, target);
        end
    endtask

    task automatic runUntilIdle(bit hold_start, int limit, string tag);
        int n = 0;
        while (m_mode != 0 && n < limit) begin
            applyStimulus(hold_start, 0, 0, 0, tag);
            n++;
        end
        tests_run++;
        assert (busy === 1'b0 && n < limit) else begin
            failed++;
            $error("[TB] FAIL %s reach idle: got busy %b expected 0", tag, busy);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        modelReset();

        // Reset values, then a one-cycle start at the default ratio of 3.
        @(negedge clk);
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 0, "start");
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, "run_d3");

        // Offer D=5 at count 0 of a D=3 period.
        runUntilCount(0, 10, "sync_reconf");
        applyStimulus(0, 0, 1, 5, "reconf5");
        for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0, 0, "run_d5");

        // Illegal ratio: consumed, error pulse, period unchanged.
        applyStimulus(0, 0, 1, 1, "illegal");
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, "after_illegal");

        // Backpressure: a second legal ratio waits until the first is applied.
        applyStimulus(0, 0, 1, 4, "offer4");
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 6, "offer6_held");
        for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0, 0, "run_after_bp");

        // Return to idle, load D=4 there, and stop at count 1.
        applyStimulus(0, 1, 0, 0, "stop1");
        runUntilIdle(0, 20, "drain1");
        applyStimulus(0, 0, 1, 4, "idle_cfg4");
        applyStimulus(1, 0, 0, 0, "start_d4");
        runUntilCount(1, 10, "to_cnt1");
        applyStimulus(0, 1, 0, 0, "stop_at1");
        runUntilIdle(0, 10, "graceful");
        applyStimulus(0, 0, 0, 0, "idle_hold");

        // Start and stop together in idle, then start held during drain.
        applyStimulus(1, 1, 0, 0, "start_stop");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, "run_ss");
        applyStimulus(0, 1, 0, 0, "stop2");
        runUntilIdle(1, 10, "drain_start");
        applyStimulus(0, 0, 0, 0, "idle_after_drain");

        // Asynchronous reset at count 3 of a D=5 period with D=7 pending.
        applyStimulus(0, 0, 1, 5, "idle_cfg5");
        applyStimulus(1, 0, 0, 0, "start_d5");
        applyStimulus(0, 0, 1, 7, "pend7");
        runUntilCount(3, 10, "to_cnt3");
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset");
        @(posedge clk);
        @(negedge clk);
        checkOutput("in_reset");
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 0, "restart");
        for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 0, "run_post_reset");

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 3) == 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 3) == 0,
                          int'($urandom_range(0, 9)),
                          "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
